cordic_prerot: RTL and testbench



---
 rtl/cordic_prerot.sv | 137 +++++++++++++
 tb/tb_cordic_prerot.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_prerot.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_prerot
//  Description : Input stage for the 6-stage CORDIC rotation core. Accepts
//                samples over valid/ready, folds the target angle into the
//                core's +/-90 degree convergence range with a 180 degree
//                pre-rotation, drives the core inputs from registers and
//                carries {valid, flip} tags alongside the core latency.
//                Flow control is credit-based against the downstream buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_prerot #(
    parameter int W       = 6,
    parameter int ANG_W   = 6,
    parameter int LAT     = 6,
    parameter int CREDITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_x,
    input  logic [W-1:0]     s_y,
    input  logic [ANG_W-1:0] s_z,
    output logic [W-1:0]     core_x,
    output logic [W-1:0]     core_y,
    output logic [ANG_W-1:0] core_z,
    output logic             o_valid,
    output logic             o_flip,
    input  logic             cr_ret,
    output logic             cr_err
);

    localparam int                 c_CNT_W   = $clog2(CREDITS + 1);
    localparam logic [c_CNT_W-1:0] c_CREDITS = c_CNT_W'(CREDITS);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);
    localparam logic [W-1:0]       c_MIN     = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]       c_MAX     = {1'b0, {(W-1){1'b1}}};

    logic [c_CNT_W-1:0] r_credits;
    logic               r_cr_err;
    logic               w_accept;

    logic [1:0]         w_quad;
    logic               w_flip;
    logic [W-1:0]       w_x_fold;
    logic [W-1:0]       w_y_fold;
    logic [ANG_W-1:0]   w_z_fold;

    logic [W-1:0]       r_core_x;
    logic [W-1:0]       r_core_y;
    logic [ANG_W-1:0]   r_core_z;
    logic [1:0]         r_tag_entry;          // {valid, flip} aligned with core_*
    logic [LAT-1:0][1:0] r_tag_line;          // tracks the core's LAT-cycle latency

    // Two's complement negation that clamps the most negative value.
    function automatic logic [W-1:0] sat_neg(input logic [W-1:0] v);
        if (v == c_MIN) begin
            return c_MAX;
        end
        return -v;
    endfunction

    // Ready depends only on the counter register, never on s_valid.
    assign s_ready  = (r_credits != '0);
    assign w_accept = s_valid & s_ready;
    assign cr_err   = r_cr_err;

    // Angles in quadrants 01/10 lie outside +/-90 deg: rotate by 180 deg
    // (MSB flip of z) and negate x/y so the core sees an equivalent target.
    assign w_quad   = s_z[ANG_W-1 -: 2];
    assign w_flip   = w_quad[1] ^ w_quad[0];
    assign w_z_fold = w_flip ? {~s_z[ANG_W-1], s_z[ANG_W-2:0]} : s_z;
    assign w_x_fold = w_flip ? sat_neg(s_x) : s_x;
    assign w_y_fold = w_flip ? sat_neg(s_y) : s_y;

    // Credit counter: one credit per accept, one back per cr_ret pulse;
    // a return with nothing outstanding is flagged and ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_credits <= c_CREDITS;
            r_cr_err  <= 1'b0;
        end else begin
            case ({w_accept, cr_ret})
                2'b10: r_credits <= r_credits - c_ONE;
                2'b01: begin
                    if (r_credits == c_CREDITS) begin
                        r_cr_err <= 1'b1;
                    end else begin
                        r_credits <= r_credits + c_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Core inputs load the folded sample on accept and zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_core_x    <= '0;
            r_core_y    <= '0;
            r_core_z    <= '0;
            r_tag_entry <= '0;
        end else if (w_accept) begin
            r_core_x    <= w_x_fold;
            r_core_y    <= w_y_fold;
            r_core_z    <= w_z_fold;
            r_tag_entry <= {1'b1, w_flip};
        end else begin
            r_core_x    <= '0;
            r_core_y    <= '0;
            r_core_z    <= '0;
            r_tag_entry <= '0;
        end
    end

    // Tag delay line advancing every cycle so tags meet the core outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_line <= '0;
        end else begin
            r_tag_line[0] <= r_tag_entry;
            for (int i = 1; i < LAT; i++) begin
                r_tag_line[i] <= r_tag_line[i-1];
            end
        end
    end

    assign core_x  = r_core_x;
    assign core_y  = r_core_y;
    assign core_z  = r_core_z;
    assign o_valid = r_tag_line[LAT-1][1];
    assign o_flip  = r_tag_line[LAT-1][0];

endmodule
`default_nettype wire

// File: tb/tb_cordic_prerot.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_prerot
//  Description : Self-checking bench for cordic_prerot. A cycle-indexed
//                behavioural model (integer credits, angle arithmetic,
//                expected-output map keyed by edge number) is compared
//                against every DUT output after every clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_prerot;

    localparam int W       = 6;
    localparam int ANG_W   = 6;
    localparam int LAT     = 6;
    localparam int CREDITS = 4;

    localparam int HALF    = 2 ** (ANG_W - 1);
    localparam int QUARTER = 2 ** (ANG_W - 2);
    localparam int XMAX    = 2 ** (W - 1) - 1;

    logic             clk;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_x;
    logic [W-1:0]     s_y;
    logic [ANG_W-1:0] s_z;
    logic [W-1:0]     core_x;
    logic [W-1:0]     core_y;
    logic [ANG_W-1:0] core_z;
    logic             o_valid;
    logic             o_flip;
    logic             cr_ret;
    logic             cr_err;

    cordic_prerot #(
        .W      (W),
        .ANG_W  (ANG_W),
        .LAT    (LAT),
        .CREDITS(CREDITS)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_x    (s_x),
        .s_y    (s_y),
        .s_z    (s_z),
        .core_x (core_x),
        .core_y (core_y),
        .core_z (core_z),
        .o_valid(o_valid),
        .o_flip (o_flip),
        .cr_ret (cr_ret),
        .cr_err (cr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int m_credits = CREDITS;
    bit m_err     = 1'b0;
    int m_cyc     = 0;
    int m_cx = 0, m_cy = 0, m_cz = 0;
    bit m_ov[int];
    bit m_of[int];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, m_cyc);
        end
    endtask

    function automatic int neg_sat(input int v);
        int r;
        r = -v;
        if (r > XMAX) r = XMAX;
        return r;
    endfunction

    // Angle fold from the geometric rule: targets beyond a quarter turn
    // either way are rotated half a turn and the vector is negated.
    task automatic fold(input int x, input int y, input int z,
                        output int fx, output int fy, output int fz, output bit fl);
        fl = (z >= QUARTER) || (z < -QUARTER);
        if (fl) begin
            fz = (z >= 0) ? z - HALF : z + HALF;
            fx = neg_sat(x);
            fy = neg_sat(y);
        end else begin
            fz = z;
            fx = x;
            fy = y;
        end
    endtask

    // Compare every DUT output against the model after each edge.
    task automatic check_outputs();
        int ev, ef;
        ev = m_ov.exists(m_cyc) ? int'(m_ov[m_cyc]) : 0;
        ef = m_of.exists(m_cyc) ? int'(m_of[m_cyc]) : 0;
        chk("s_ready", int'(s_ready), int'(m_credits != 0));
        chk("core_x",  int'($signed(core_x)), m_cx);
        chk("core_y",  int'($signed(core_y)), m_cy);
        chk("core_z",  int'($signed(core_z)), m_cz);
        chk("o_valid", int'(o_valid), ev);
        chk("o_flip",  int'(o_flip),  ef);
        chk("cr_err",  int'(cr_err),  int'(m_err));
    endtask

    // One clock: decide accept from the model, advance, then compare.
    task automatic tick(output bit acc);
        int fx, fy, fz;
        bit fl;
        acc = rst_n && s_valid && (m_credits != 0);
        fold(int'($signed(s_x)), int'($signed(s_y)), int'($signed(s_z)), fx, fy, fz, fl);
        @(posedge clk);
        m_cyc++;
        if (!rst_n) begin
            m_credits = CREDITS;
            m_err     = 1'b0;
            m_ov.delete();
            m_of.delete();
            m_cx = 0; m_cy = 0; m_cz = 0;
        end else begin
            if (cr_ret && !acc && m_credits == CREDITS) begin
                m_err = 1'b1;
            end else begin
                m_credits = m_credits - int'(acc) + int'(cr_ret);
            end
            if (acc) begin
                m_cx = fx; m_cy = fy; m_cz = fz;
                m_ov[m_cyc + LAT] = 1'b1;
                m_of[m_cyc + LAT] = fl;
            end else begin
                m_cx = 0; m_cy = 0; m_cz = 0;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    initial begin
        bit a;
        int cnt;

        rst_n = 1'b0; s_valid = 1'b0; cr_ret = 1'b0;
        s_x = '0; s_y = '0; s_z = '0;
        #2;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        chk("reset_s_ready", int'(s_ready), 1);
        chk("reset_o_valid", int'(o_valid), 0);

        // Pass-through sample, tag appears exactly LAT edges later
        s_valid = 1'b1; s_x = 6'd10; s_y = 6'd5; s_z = 6'd8;
        tick(a);
        s_valid = 1'b0;
        chk("d1_accept", int'(a), 1);
        chk("d1_core_x", int'($signed(core_x)), 10);
        chk("d1_core_y", int'($signed(core_y)), 5);
        chk("d1_core_z", int'($signed(core_z)), 8);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin tick(a); cnt += int'(o_valid); end
        chk("d1_early_valid", cnt, 0);
        tick(a);
        chk("d1_o_valid", int'(o_valid), 1);
        chk("d1_o_flip",  int'(o_flip), 0);
        tick(a);
        chk("d1_o_valid_one_cycle", int'(o_valid), 0);

        // Two folded samples back to back
        s_valid = 1'b1; s_x = 6'd10; s_y = -6'sd7; s_z = 6'd40;
        tick(a);
        chk("d2_core_x", int'($signed(core_x)), -10);
        chk("d2_core_y", int'($signed(core_y)), 7);
        chk("d2_core_z", int'($signed(core_z)), 8);
        s_x = -6'sd32; s_y = 6'd3; s_z = 6'd20;
        tick(a);
        s_valid = 1'b0;
        chk("d3_core_x", int'($signed(core_x)), 31);
        chk("d3_core_y", int'($signed(core_y)), -3);
        chk("d3_core_z", int'($signed(core_z)), -12);
        idle(4);
        tick(a);
        chk("d2_o_valid", int'(o_valid), 1);
        chk("d2_o_flip",  int'(o_flip), 1);
        tick(a);
        chk("d3_o_flip",  int'(o_flip), 1);

        // Return the three outstanding credits
        cr_ret = 1'b1; idle(3); cr_ret = 1'b0;

        // Burst until credits run out, then one return buys one sample
        s_valid = 1'b1; cnt = 0;
        for (int i = 0; i < 6; i++) begin tick(a); cnt += int'(a); end
        chk("burst_accepts", cnt, 4);
        chk("burst_s_ready", int'(s_ready), 0);
        cr_ret = 1'b1; tick(a); cr_ret = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin tick(a); cnt += int'(a); end
        chk("one_return_one_accept", cnt, 1);
        chk("after_return_s_ready", int'(s_ready), 0);

        // Accept and return together at credits=2 leaves 2
        s_valid = 1'b0; cr_ret = 1'b1; idle(2);
        s_valid = 1'b1; tick(a); cr_ret = 1'b0;
        chk("same_cycle_accept", int'(a), 1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin tick(a); cnt += int'(a); end
        chk("same_cycle_hold", cnt, 2);

        // Refill, then one surplus return raises the sticky error
        s_valid = 1'b0; cr_ret = 1'b1; idle(4);
        chk("cr_err_before", int'(cr_err), 0);
        tick(a); cr_ret = 1'b0;
        chk("cr_err_set", int'(cr_err), 1);
        chk("cr_err_full_ready", int'(s_ready), 1);
        idle(3);
        chk("cr_err_sticky", int'(cr_err), 1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            cr_ret  = ($urandom_range(0, 2) == 0);
            rst_n   = ($urandom_range(0, 149) != 0);
            s_x = W'($urandom);
            s_y = W'($urandom);
            s_z = ANG_W'($urandom);
            tick(a);
        end
        rst_n = 1'b1; s_valid = 1'b0; cr_ret = 1'b0;

        // Reset in the middle of a drain
        rst_n = 1'b0; tick(a); rst_n = 1'b1;
        s_valid = 1'b1; s_x = 6'd9; s_y = 6'd9; s_z = 6'd3;
        idle(4);
        s_valid = 1'b0;
        idle(3);
        rst_n = 1'b0; tick(a); rst_n = 1'b1;
        chk("mid_rst_core_x", int'(core_x), 0);
        chk("mid_rst_s_ready", int'(s_ready), 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin tick(a); cnt += int'(o_valid); end
        chk("mid_rst_no_valid", cnt, 0);
        s_valid = 1'b1; cnt = 0;
        for (int i = 0; i < 6; i++) begin tick(a); cnt += int'(a); end
        chk("mid_rst_credits", cnt, 4);
        s_valid = 1'b0;
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
